// File: rtl/command_credit_arbiter_pkg.sv
// Shared types and helpers for the PSL command credit arbiter.
//   CreditInterfaceInput  : credit-side inputs (init pulse, room, response delta)
//   CreditInterfaceOutput : registered credit count presented to software/PSL glue
//   credit_next()         : one-edge credit update with saturation and error flag
package command_credit_arbiter_pkg;

    localparam int RESERVE_CREDITS_DEFAULT = 1;

    typedef logic [7:0] credit_t;

    typedef struct packed {
        logic       credit_init;
        credit_t    room;
        logic       rsp_valid;
        logic [8:0] rsp_credits;
    } CreditInterfaceInput;

    typedef struct packed {
        credit_t credits;
    } CreditInterfaceOutput;

    typedef struct packed {
        credit_t credits;
        logic    error;
    } credit_update_t;

    // Grant and response are folded into one 10-bit signed sum so a
    // simultaneous issue and return is never lost; the result saturates
    // to [0, room] and flags any clipping.
    function automatic credit_update_t credit_next(
        input credit_t             credits,
        input logic                grant,
        input CreditInterfaceInput cin
    );
        credit_update_t    r;
        logic signed [9:0] delta;
        logic signed [9:0] nxt;
        r.credits = credits;
        r.error   = 1'b0;
        delta     = cin.rsp_valid ? $signed({cin.rsp_credits[8], cin.rsp_credits}) : 10'sd0;
        nxt       = $signed({2'b00, credits}) - $signed({9'd0, grant}) + delta;
        if (cin.credit_init) begin
            r.credits = cin.room;
        end else if (nxt < 0) begin
            r.credits = '0;
            r.error   = 1'b1;
        end else if (nxt > $signed({2'b00, cin.room})) begin
            r.credits = cin.room;
            r.error   = 1'b1;
        end else begin
            r.credits = nxt[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/command_credit_arbiter_if.sv
// Bus bundle between AFU command engines / PSL glue (master) and the arbiter (slave).
//   enabled, credit_init, room, rsp_valid, rsp_credits : credit control inputs
//   req_valid, req_cmd, req_ready                      : per-requester handshake
//   cmd_out_valid, cmd_out, cmd_out_src                : registered command to PSL
//   credits_out, credit_error                          : credit status
interface command_credit_arbiter_if
    import command_credit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 64
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                     enabled;
    logic                     credit_init;
    credit_t                  room;
    logic                     rsp_valid;
    logic [8:0]               rsp_credits;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cmd_out_valid;
    logic [CMD_W-1:0]         cmd_out;
    logic [IDX_W-1:0]         cmd_out_src;
    CreditInterfaceOutput     credits_out;
    logic                     credit_error;

    modport master (
        output enabled, credit_init, room, rsp_valid, rsp_credits, req_valid, req_cmd,
        input  req_ready, cmd_out_valid, cmd_out, cmd_out_src, credits_out, credit_error
    );

    modport slave (
        input  enabled, credit_init, room, rsp_valid, rsp_credits, req_valid, req_cmd,
        output req_ready, cmd_out_valid, cmd_out, cmd_out_src, credits_out, credit_error
    );

endinterface

// File: rtl/command_credit_arbiter_rr.sv
// Combinational round-robin pick: first set bit of req_i at or after ptr_i.
//   req_i   : eligible requesters
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot winner (zero if none)
//   idx_o   : encoded winner
//   any_o   : at least one requester eligible
module round_robin_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_credit_arbiter.sv
// Shares PSL command credits among NUM_REQ command sources, round-robin,
// and registers the winning command toward the PSL command bus.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : credit control, requester handshake, registered command
//                  output and credit status (see command_credit_arbiter_if)
module command_credit_arbiter
    import command_credit_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int CMD_W           = 64,
    parameter int RESERVE_CREDITS = RESERVE_CREDITS_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    command_credit_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        credit_t          credits;
        logic [IDX_W-1:0] rr_ptr;
        logic             error;
    } ArbiterCreditState;

    ArbiterCreditState   state_q, state_d;
    logic                cmd_out_valid_q, cmd_out_valid_d;
    logic [CMD_W-1:0]    cmd_out_q, cmd_out_d;
    logic [IDX_W-1:0]    cmd_out_src_q, cmd_out_src_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                do_grant;
    logic [CMD_W-1:0]    cmd_sel;
    CreditInterfaceInput cin;
    credit_update_t      upd;

    // Requester 0 may spend the reserved credits; everyone else must leave them.
    assign eligible = bus.req_valid &
                      {{(NUM_REQ-1){state_q.credits > credit_t'(RESERVE_CREDITS)}},
                       (state_q.credits != '0)};

    round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (eligible),
        .ptr_i   (state_q.rr_ptr),
        .grant_o (grant_onehot),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign do_grant      = bus.enabled & grant_any & ~bus.credit_init & ~reset;
    assign bus.req_ready = do_grant ? grant_onehot : '0;

    assign cin = '{credit_init: bus.credit_init, room: bus.room,
                   rsp_valid: bus.rsp_valid, rsp_credits: bus.rsp_credits};
    assign upd = credit_next(state_q.credits, do_grant, cin);

    always_comb begin
        cmd_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                cmd_sel = bus.req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_out_valid_d = do_grant;
        cmd_out_d       = cmd_out_q;
        cmd_out_src_d   = cmd_out_src_q;

        state_d.credits = upd.credits;
        state_d.error   = bus.credit_init ? 1'b0 : (state_q.error | upd.error);

        if (do_grant) begin
            state_d.rr_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cmd_out_d      = cmd_sel;
            cmd_out_src_d  = grant_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= '0;
            cmd_out_valid_q <= 1'b0;
            cmd_out_q       <= '0;
            cmd_out_src_q   <= '0;
        end else begin
            state_q         <= state_d;
            cmd_out_valid_q <= cmd_out_valid_d;
            cmd_out_q       <= cmd_out_d;
            cmd_out_src_q   <= cmd_out_src_d;
        end
    end

    assign bus.cmd_out_valid       = cmd_out_valid_q;
    assign bus.cmd_out             = cmd_out_q;
    assign bus.cmd_out_src         = cmd_out_src_q;
    assign bus.credits_out.credits = state_q.credits;
    assign bus.credit_error        = state_q.error;

endmodule
